// File: rtl/snn_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_readout_pkg
// Description : Shared types, default sizing constants and the saturating
//               increment helper used by the spike readout / argmax block.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_readout_pkg;

    // Defaults that line up with snn_core's spike vector width.
    localparam int c_def_n  = 96;
    localparam int c_def_cw = 8;
    localparam int c_def_tw = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        OUT   = 2'd3
    } rd_state_t;

    // Operates on a 32-bit container so any counter width up to 32 can share
    // it; callers zero-extend in and truncate the result back out.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic        b,
                                            input logic [31:0] max_val);
        if (b && (cnt < max_val))
            return cnt + 32'd1;
        else
            return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_spike_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : snn_spike_cnt_bank
// Description : N saturating CW-bit spike counters with synchronous clear,
//               per-neuron increment and one indexed read port.
// Ports       : clk, rstn      - clock, async active-low reset
//               clr            - zero every counter
//               inc_en         - accumulate inc_vec this cycle
//               inc_vec[N]     - bit n increments counter n
//               rd_addr[IW]    - read index (>= N reads 0)
//               rd_data[CW]    - combinational counter value at rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module snn_spike_cnt_bank
    import snn_readout_pkg::*;
#(
    parameter int N  = c_def_n,
    parameter int CW = c_def_cw,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc_en,
    input  logic [N-1:0]  inc_vec,
    input  logic [IW-1:0] rd_addr,
    output logic [CW-1:0] rd_data
);

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [IW:0]   c_n       = (IW+1)'(N);

    logic [CW-1:0] r_cnt [N];

    generate
        for (genvar n = 0; n < N; n++) begin : g_cnt
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cnt[n] <= '0;
                end else if (clr) begin
                    r_cnt[n] <= '0;
                end else if (inc_en) begin
                    r_cnt[n] <= CW'(sat_inc(32'(r_cnt[n]), inc_vec[n], 32'(c_cnt_max)));
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < c_n)
            rd_data = r_cnt[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/snn_readout_argmax.sv
`default_nettype none
// ============================================================================
// Module      : snn_readout_argmax
// Description : Counts spikes per neuron over a window of win_len timesteps,
//               scans the counts one neuron per cycle for the argmax (lowest
//               index wins ties) and presents the winner on a valid/ready
//               output.
// Ports       : clk, rstn            - clock, async active-low reset
//               start, win_len       - open a window (accepted in IDLE only)
//               spk_valid, spikes_vec- one timestep of spike bits
//               busy                 - high outside IDLE
//               out_valid/out_ready  - result handshake
//               out_class, out_count - winning index and its count
//               hist_rd_addr/_data   - count readback (SNN_READOUT_HIST_EN)
// Config      : define SNN_READOUT_HIST_EN to add the count readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_readout_argmax
    import snn_readout_pkg::*;
#(
    parameter int N  = c_def_n,
    parameter int CW = c_def_cw,
    parameter int TW = c_def_tw,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [TW-1:0] win_len,
    input  logic          spk_valid,
    input  logic [N-1:0]  spikes_vec,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_class,
`ifdef SNN_READOUT_HIST_EN
    input  logic [IW-1:0] hist_rd_addr,
    output logic [CW-1:0] hist_rd_data,
`endif
    output logic [CW-1:0] out_count
);

    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    rd_state_t     r_state;
    logic [TW-1:0] r_win_len;
    logic [TW-1:0] r_tick;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_best;
    logic [IW-1:0] r_best_idx;
    logic          r_busy;
    logic          r_out_valid;
    logic [IW-1:0] r_out_class;
    logic [CW-1:0] r_out_count;

    logic          w_clr;
    logic          w_inc_en;
    logic [IW-1:0] w_rd_addr;
    logic [CW-1:0] w_rd_data;
    logic [TW-1:0] w_tick_nxt;
    logic          w_better;

    assign w_clr      = (r_state == IDLE) && start;
    assign w_inc_en   = (r_state == ACCUM) && spk_valid;
    assign w_tick_nxt = r_tick + 1'b1;
    // Strict compare keeps the earlier (lower) index on a tie.
    assign w_better   = (w_rd_data > r_best);

    // The single read mux belongs to the scan while scanning; otherwise it
    // is free for the readback port.
`ifdef SNN_READOUT_HIST_EN
    assign w_rd_addr = (r_state == SCAN) ? r_idx : hist_rd_addr;
`else
    assign w_rd_addr = r_idx;
`endif

    snn_spike_cnt_bank #(
        .N  (N),
        .CW (CW),
        .IW (IW)
    ) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (w_clr),
        .inc_en  (w_inc_en),
        .inc_vec (spikes_vec),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_win_len   <= '0;
            r_tick      <= '0;
            r_idx       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_win_len  <= win_len;
                        r_tick     <= '0;
                        r_idx      <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                        r_busy     <= 1'b1;
                        // An empty window skips straight to a scan of zeros.
                        r_state    <= (win_len == '0) ? SCAN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (spk_valid) begin
                        r_tick <= w_tick_nxt;
                        if (w_tick_nxt == r_win_len)
                            r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_better) begin
                        r_best     <= w_rd_data;
                        r_best_idx <= r_idx;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                        r_out_class <= w_better ? r_idx : r_best_idx;
                        r_out_count <= w_better ? w_rd_data : r_best;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SNN_READOUT_HIST_EN
    logic [CW-1:0] r_hist_data;

    // Counts are only meaningful once the window has closed and been scanned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_hist_data <= '0;
        else if ((r_state == IDLE) || (r_state == OUT))
            r_hist_data <= w_rd_data;
        else
            r_hist_data <= '0;
    end

    assign hist_rd_data = r_hist_data;
`endif

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_snn_readout_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_readout_argmax
// Description : Directed self-checking bench for snn_readout_argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_readout_argmax;

    localparam int N  = 96;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] win_len = '0;
    logic          spk_valid = 1'b0;
    logic [N-1:0]  spikes_vec = '0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_class;
    logic [CW-1:0] out_count;
`ifdef SNN_READOUT_HIST_EN
    logic [IW-1:0] hist_rd_addr = '0;
    logic [CW-1:0] hist_rd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    snn_readout_argmax #(.N(N), .CW(CW), .TW(TW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .win_len    (win_len),
        .spk_valid  (spk_valid),
        .spikes_vec (spikes_vec),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
`ifdef SNN_READOUT_HIST_EN
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
`endif
        .out_count  (out_count)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [TW-1:0] len, input logic sv, input logic [N-1:0] v);
        start = 1'b1; win_len = len; spk_valid = sv; spikes_vec = v;
        step();
        start = 1'b0; spk_valid = 1'b0; spikes_vec = '0;
    endtask

    task automatic tick(input logic [N-1:0] v);
        spk_valid = 1'b1; spikes_vec = v;
        step();
        spk_valid = 1'b0; spikes_vec = '0;
    endtask

    // Edges from the call until out_valid is seen; bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 500) begin
            step();
            edges++;
        end
        if (!out_valid) begin
            n_checks++; n_errors++;
            $display("FAIL wait_valid: out_valid=%0b after %0d edges, required 1", out_valid, edges);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL handshake: out_valid=%0b busy=%0b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_class !== 7'd0 || out_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset: busy=%0b valid=%0b class=%0d count=%0d, required 0 0 0 0",
                     busy, out_valid, out_class, out_count);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [N-1:0] v;
        int e;
        do_start(16'd5, 1'b0, '0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_busy: busy=%0b, required 1", busy);
        end
        for (int t = 0; t < 5; t++) begin
            v = '0; v[7] = 1'b1;
            if (t < 3) v[3] = 1'b1;
            tick(v);
        end
        wait_valid(e);
        n_checks++;
        if (e !== N) begin
            n_errors++;
            $display("FAIL basic_latency: edges=%0d, required %0d", e, N);
        end
        n_checks++;
        if (out_class !== 7'd7 || out_count !== 8'd5) begin
            n_errors++;
            $display("FAIL basic_result: class=%0d count=%0d, required 7 5", out_class, out_count);
        end
`ifdef SNN_READOUT_HIST_EN
        hist_rd_addr = 7'd3; step();
        n_checks++;
        if (hist_rd_data !== 8'd3) begin
            n_errors++; $display("FAIL hist_3: data=%0d, required 3", hist_rd_data);
        end
        hist_rd_addr = 7'd7; step();
        n_checks++;
        if (hist_rd_data !== 8'd5) begin
            n_errors++; $display("FAIL hist_7: data=%0d, required 5", hist_rd_data);
        end
        hist_rd_addr = 7'd100; step();
        n_checks++;
        if (hist_rd_data !== 8'd0) begin
            n_errors++; $display("FAIL hist_100: data=%0d, required 0", hist_rd_data);
        end
`endif
        handshake();
        n_checks++;
        if (out_class !== 7'd7 || out_count !== 8'd5) begin
            n_errors++;
            $display("FAIL basic_hold_idle: class=%0d count=%0d, required 7 5", out_class, out_count);
        end
    endtask

    // Start cycle carries spikes on neuron 20 that must not be counted.
    task automatic test_tie();
        logic [N-1:0] v;
        int e;
        v = '0; v[20] = 1'b1;
        do_start(16'd8, 1'b1, v);
        for (int t = 0; t < 8; t++) begin
            v = '0;
            if (t < 4) begin v[10] = 1'b1; v[20] = 1'b1; end
            tick(v);
        end
        wait_valid(e);
        n_checks++;
        if (out_class !== 7'd10 || out_count !== 8'd4) begin
            n_errors++;
            $display("FAIL tie: class=%0d count=%0d, required 10 4", out_class, out_count);
        end
        handshake();
    endtask

    task automatic test_saturation();
        logic [N-1:0] v;
        int e;
        v = '0; v[95] = 1'b1;
        do_start(16'd300, 1'b0, '0);
        for (int t = 0; t < 300; t++) tick(v);
        wait_valid(e);
        n_checks++;
        if (out_class !== 7'd95 || out_count !== 8'd255) begin
            n_errors++;
            $display("FAIL saturation: class=%0d count=%0d, required 95 255", out_class, out_count);
        end
        handshake();
    endtask

    task automatic test_zero_window_hold();
        int e;
        do_start(16'd0, 1'b0, '0);
        wait_valid(e);
        n_checks++;
        if (e !== N || out_class !== 7'd0 || out_count !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_window: edges=%0d class=%0d count=%0d, required %0d 0 0",
                     e, out_class, out_count, N);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin start = 1'b1; win_len = 16'd7; end
            step();
            start = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_class !== 7'd0 || out_count !== 8'd0) begin
                n_errors++;
                $display("FAIL hold_%0d: valid=%0b busy=%0b class=%0d count=%0d, required 1 1 0 0",
                         i, out_valid, busy, out_class, out_count);
            end
        end
        handshake();
    endtask

    task automatic test_reset_mid_window();
        logic [N-1:0] v;
        int e;
        v = '0; v[60] = 1'b1;
        do_start(16'd10, 1'b0, '0);
        for (int t = 0; t < 3; t++) tick(v);
        rstn = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_class !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_mid: busy=%0b valid=%0b class=%0d, required 0 0 0",
                     busy, out_valid, out_class);
        end
        step();
        rstn = 1'b1;
        step();
        do_start(16'd2, 1'b0, '0);
        v = '0; v[50] = 1'b1; v[60] = 1'b1;
        tick(v);
        v = '0; v[50] = 1'b1;
        tick(v);
        wait_valid(e);
        n_checks++;
        if (out_class !== 7'd50 || out_count !== 8'd2) begin
            n_errors++;
            $display("FAIL reset_new_window: class=%0d count=%0d, required 50 2", out_class, out_count);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_zero_window_hold();
        test_reset_mid_window();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
